// File: rtl/alu_datapath.sv
// alu_datapath: 8-bit A/Q/M datapath for ADD, SUB, Booth MUL and DIV.
// Executes the control unit's 11-bit micro-op word; registered output bus.
module alu_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [10:0]  control,
  output logic         Q0,
  output logic         Q_1,
  output logic         A7,
  output logic         count,
  output logic [W-1:0] outbus,
  output logic         out_valid,
  output logic         carry
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_q;
  logic [W-1:0] r_m;
  logic         r_q1;
  logic         r_qbit;
  logic         r_carry;
  logic [2:0]   r_cnt;
  logic [W-1:0] r_out;
  logic         r_valid;

  logic         w_add_en;
  logic         w_sub;
  logic [W-1:0] w_bop;
  logic [W-1:0] w_sum;
  logic         w_cout;
  logic [W-1:0] w_pre;
  logic [W-1:0] w_a_nxt;
  logic [W-1:0] w_q_nxt;
  logic         w_q1_nxt;
  logic [2:0]   w_cnt_nxt;
  logic [W-1:0] w_out_nxt;

  assign w_add_en = control[3] | control[4] | control[5];
  assign w_sub    = control[5];
  assign w_bop    = w_sub ? ~r_m : r_m;

  // Shared adder; subtract is A + ~M + 1
  always_comb begin
    {w_cout, w_sum} = {1'b0, r_a} + {1'b0, w_bop}
                    + {{W{1'b0}}, w_sub};
  end

  // Shifts act on the adder result so a Booth step fits one cycle
  assign w_pre = w_add_en ? w_sum : r_a;

  // A next-state: clear > load > add/shift > hold
  always_comb begin
    w_a_nxt = w_pre;
    if (control[2])
      w_a_nxt = '0;
    else if (control[0])
      w_a_nxt = op_a;
    else if (control[6])
      w_a_nxt = {w_pre[W-1], w_pre[W-1:1]};
    else if (control[7])
      w_a_nxt = {w_pre[W-2:0], r_q[W-1]};
  end

  // Q and Q_1 next-state; loads override shifts
  always_comb begin
    w_q_nxt  = r_q;
    w_q1_nxt = r_q1;
    if (control[1])
      w_q_nxt = op_a;
    else if (control[6])
      w_q_nxt = {w_pre[0], r_q[W-1:1]};
    else if (control[7])
      w_q_nxt = {r_q[W-2:0], r_qbit};
    if (control[2] || control[1])
      w_q1_nxt = 1'b0;
    else if (control[6])
      w_q1_nxt = r_q[0];
  end

  // Step counter and output bus selection
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (control[2])
      w_cnt_nxt = 3'd0;
    else if (control[8])
      w_cnt_nxt = r_cnt + 3'd1;
    w_out_nxt = r_out;
    if (control[10])
      w_out_nxt = r_a;
    else if (control[9])
      w_out_nxt = r_q;
  end

  // Register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_q1    <= 1'b0;
      r_qbit  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= 3'd0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_a     <= w_a_nxt;
      r_q     <= w_q_nxt;
      r_q1    <= w_q1_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_valid <= control[9] | control[10];
      if (control[0])
        r_m <= op_b;
      if (control[4])
        r_carry <= w_cout;
      if (control[5])
        r_qbit <= ~w_sum[W-1];
    end
  end

  assign Q0        = r_q[0];
  assign Q_1       = r_q1;
  assign A7        = r_a[W-1];
  assign count     = (r_cnt == 3'd7);
  assign outbus    = r_out;
  assign out_valid = r_valid;
  assign carry     = r_carry;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed bench with an output scoreboard.
// Expected bytes are queued when C9/C10 are issued, checked on out_valid.
module tb_alu_datapath;

  logic        clk;
  logic        reset;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [10:0] control;
  logic        Q0;
  logic        Q_1;
  logic        A7;
  logic        count;
  logic [7:0]  outbus;
  logic        out_valid;
  logic        carry;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbq[$];

  logic [7:0]  mA, mQ, mM;
  logic        mQ1;
  logic [16:0] t;
  logic [10:0] k;

  alu_datapath #(.W(8)) dut (
    .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b),
    .control(control), .Q0(Q0), .Q_1(Q_1), .A7(A7),
    .count(count), .outbus(outbus), .out_valid(out_valid),
    .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] c(input int i);
    return 11'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one control word for one clock, then score the output bus
  task automatic tick(input logic [10:0] ctrl);
    @(negedge clk);
    control = ctrl;
    @(posedge clk);
    #1;
    control = '0;
    chk("out_valid", {7'd0, out_valid}, {7'd0, ctrl[9] | ctrl[10]});
    if (out_valid) begin
      if (sbq.size() == 0)
        chk("sb_unexpected", 8'd1, 8'd0);
      else
        chk("outbus", outbus, sbq.pop_front());
    end
  endtask

  // One Booth step chosen from the bench's own model of {A,Q,Q_1}
  task automatic booth_step(input logic [10:0] extra);
    k = c(6) | c(8) | extra;
    if ({mQ[0], mQ1} == 2'b01) begin
      k = k | c(3);
      mA = mA + mM;
    end else if ({mQ[0], mQ1} == 2'b10) begin
      k = k | c(5);
      mA = mA - mM;
    end
    if (extra[9])
      sbq.push_back(mQ);
    t = {mA, mQ, mQ1};
    t = {t[16], t[16:1]};
    {mA, mQ, mQ1} = t;
    tick(k);
    chk("booth_Q0", {7'd0, Q0}, {7'd0, mQ[0]});
    chk("booth_Q_1", {7'd0, Q_1}, {7'd0, mQ1});
    chk("booth_A7", {7'd0, A7}, {7'd0, mA[7]});
  endtask

  initial begin
    reset   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    control = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Q0", {7'd0, Q0}, 8'd0);
    chk("rst_Q_1", {7'd0, Q_1}, 8'd0);
    chk("rst_A7", {7'd0, A7}, 8'd0);
    chk("rst_count", {7'd0, count}, 8'd0);
    chk("rst_carry", {7'd0, carry}, 8'd0);
    chk("rst_outbus", outbus, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Counter wrap: count high at cnt==7, i.e. pulses 7 and 15
    for (int i = 1; i <= 15; i++) begin
      tick(c(8));
      chk($sformatf("count_p%0d", i), {7'd0, count},
          {7'd0, (i == 7) || (i == 15)});
    end

    // ADD 3C+15
    op_a = 8'h3C; op_b = 8'h15;
    tick(c(0));
    tick(c(4));
    chk("add_carry", {7'd0, carry}, 8'd0);
    sbq.push_back(8'h51);
    tick(c(10));
    tick(11'd0);

    // ADD with carry-out: F0+20
    op_a = 8'hF0; op_b = 8'h20;
    tick(c(0));
    tick(c(4));
    chk("add_cout", {7'd0, carry}, 8'd1);
    sbq.push_back(8'h10);
    tick(c(10));

    // SUB 10-20
    op_a = 8'h10; op_b = 8'h20;
    tick(c(0));
    tick(c(4) | c(5));
    chk("sub_A7", {7'd0, A7}, 8'd1);
    chk("sub_carry", {7'd0, carry}, 8'd0);
    sbq.push_back(8'hF0);
    tick(c(10));

    // Booth MUL 6 * -3
    op_a = 8'd6; op_b = 8'hFD;
    mA = 8'd0; mQ = 8'd6; mM = 8'hFD; mQ1 = 1'b0;
    tick(c(0) | c(1) | c(2));
    for (int i = 0; i < 8; i++) begin
      booth_step(11'd0);
      chk($sformatf("mul_count_s%0d", i + 1), {7'd0, count},
          {7'd0, i == 6});
    end
    sbq.push_back(8'hFF);
    tick(c(10));
    sbq.push_back(8'hEE);
    tick(c(9));

    // Priority: clear beats load, M still loads
    op_a = 8'hAA; op_b = 8'h5B;
    tick(c(0) | c(2));
    sbq.push_back(8'h00);
    tick(c(10));
    tick(c(3));
    op_a = 8'h81;
    tick(c(1));
    sbq.push_back(8'h5B);
    tick(c(9) | c(10));
    tick(c(6) | c(7));
    chk("shr_Q_1", {7'd0, Q_1}, 8'd1);
    chk("shr_Q0", {7'd0, Q0}, 8'd0);
    sbq.push_back(8'h2D);
    tick(c(10));
    sbq.push_back(8'hC0);
    tick(c(9));

    // Async reset in the middle of a multiply
    op_a = 8'd6; op_b = 8'hFD;
    mA = 8'd0; mQ = 8'd6; mM = 8'hFD; mQ1 = 1'b0;
    tick(c(0) | c(1) | c(2));
    for (int i = 0; i < 6; i++)
      booth_step(11'd0);
    booth_step(c(9));
    chk("pre_rst_count", {7'd0, count}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_Q0", {7'd0, Q0}, 8'd0);
    chk("arst_Q_1", {7'd0, Q_1}, 8'd0);
    chk("arst_A7", {7'd0, A7}, 8'd0);
    chk("arst_count", {7'd0, count}, 8'd0);
    chk("arst_carry", {7'd0, carry}, 8'd0);
    chk("arst_outbus", outbus, 8'd0);
    chk("arst_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(11'd0);
    chk("post_rst_outbus", outbus, 8'd0);
    chk("post_rst_A7", {7'd0, A7}, 8'd0);

    chk("sb_drain", 8'(sbq.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
